// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter with bounded hold time
// A grant is released when its owner drops req or after MAX_HOLD cycles.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [1:0]    id_nxt;
  logic          valid_nxt;
  logic [3:0]    gnt_nxt;
  logic          rel;
  logic [1:0]    base;
  logic [1:0]    winner;

  // On release the search already starts past the current owner.
  assign rel  = (state == GRANT) && (!req[gnt_id] || (hold_cnt == HOLD_LAST));
  assign base = rel ? gnt_id + 2'd1 : ptr;

  // Scan from the farthest offset back so the nearest set bit wins.
  always_comb begin
    winner = base;
    for (int k = 3; k >= 0; k--) begin
      if (req[base + 2'(k)]) winner = base + 2'(k);
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    id_nxt    = gnt_id;
    valid_nxt = gnt_valid;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (|req) begin
          state_nxt = GRANT;
          id_nxt    = winner;
          hold_nxt  = '0;
          valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (!rel) begin
          hold_nxt = hold_cnt + 1'b1;
        end else begin
          ptr_nxt  = gnt_id + 2'd1;
          hold_nxt = '0;
          if (|req) begin
            id_nxt    = winner;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    gnt_nxt = valid_nxt ? (4'b0001 << id_nxt) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'b00;
      hold_cnt  <= '0;
      gnt_id    <= 2'b00;
      gnt_valid <= 1'b0;
      gnt       <= 4'b0000;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
      gnt       <= gnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - bench for rr_arbiter_4
// Directed scenarios plus random traffic against an integer reference model.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 8;
  localparam int BOUND    = 3 * MAX_HOLD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_valid = 0;
  int m_id    = 0;
  int m_hold  = 0;
  int m_ptr   = 0;

  int wait_cnt [4];
  int max_wait = 0;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] q, input int p);
    for (int k = 0; k < 4; k++)
      if (q[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q);
    if (r) begin
      m_valid = 0; m_id = 0; m_hold = 0; m_ptr = 0;
    end else if (!m_valid) begin
      if (q != 0) begin
        m_id = first_from(q, m_ptr); m_valid = 1; m_hold = 0;
      end
    end else if (q[m_id] && m_hold != MAX_HOLD - 1) begin
      m_hold++;
    end else begin
      m_ptr  = (m_id + 1) % 4;
      m_hold = 0;
      if (q != 0) m_id = first_from(q, m_ptr);
      else m_valid = 0;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    logic [3:0] exp_gnt;
    @(negedge clk);
    rst = r;
    req = q;
    model_step(r, q);
    @(posedge clk);
    #1;
    exp_gnt = m_valid ? (4'b0001 << m_id) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_valid));
    chk("gnt_id", 32'(gnt_id), 32'(m_id));
    if (m_valid) chk("hold_cnt", 32'(dut.hold_cnt), 32'(m_hold));
    chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (!r && q[i] && !gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  initial begin
    logic [3:0] q;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

    // reset state and quiet idle
    do_reset();
    step(1'b1, 4'b1111);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_id", 32'(gnt_id), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0000);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_valid", 32'(gnt_valid), 32'd0);

    // single request
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0100);
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_id", 32'(gnt_id), 32'd2);
    end
    step(1'b0, 4'b0000);
    chk("single_drop", 32'(gnt), 32'd0);
    chk("single_keep_id", 32'(gnt_id), 32'd2);

    // round robin, winners drop after one cycle
    do_reset();
    q = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, q);
      chk("rr_order", 32'(gnt), 32'(4'b0001 << k));
      q[k] = 1'b0;
    end
    step(1'b0, 4'b0000);
    chk("rr_end", 32'(gnt), 32'd0);

    // timeout alternation between two requesters
    do_reset();
    for (int k = 0; k < 6 * MAX_HOLD; k++) begin
      step(1'b0, 4'b0011);
      chk("timeout_alt", 32'(gnt), ((k / MAX_HOLD) % 2 == 0) ? 32'h1 : 32'h2);
    end

    // sole requester re-granted after timeout
    do_reset();
    for (int k = 0; k < 3 * MAX_HOLD; k++) begin
      step(1'b0, 4'b1000);
      chk("sole_gnt", 32'(gnt), 32'h8);
      chk("sole_hold", 32'(dut.hold_cnt), 32'(k % MAX_HOLD));
    end

    // reset in the middle of a grant
    do_reset();
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    chk("mid_pre", 32'(gnt), 32'h4);
    step(1'b1, 4'b1100);
    chk("mid_rst", 32'(gnt), 32'h0);
    step(1'b0, 4'b1100);
    chk("mid_after", 32'(gnt), 32'h4);

    // random traffic, bits toggle rarely so requests persist
    do_reset();
    max_wait = 0;
    q = 4'b0000;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) q[i] = ~q[i];
      step(1'b0, q);
    end
    chk("starve_bound", 32'(max_wait <= BOUND), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive cycles one requester may hold a grant; the legal range is 2..256.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: request lines; req[i]=1 means requester i wants the shared resource.
REQ-005 The block SHALL have port gnt, output, 4 bits: registered one-hot grant.
REQ-006 The block SHALL have port gnt_id, output, 2 bits: registered binary index of the granted requester.
REQ-007 The block SHALL have port gnt_valid, output, 1 bit: registered flag, 1 while a grant is active.

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-009 The block SHALL keep a 2-bit priority pointer ptr; the arbitration search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-010 In IDLE with req != 0, the block SHALL select the first set req bit in search order, enter GRANT, and assert the grant on the next edge (1-cycle latency from req to gnt).
REQ-011 In IDLE with req == 0, the block SHALL remain in IDLE with gnt=0, gnt_valid=0, and gnt_id holding its last value.
REQ-012 gnt SHALL equal the 2-to-4 one-hot decode of gnt_id when gnt_valid=1 (00->0001, 01->0010, 10->0100, 11->1000), and 4'b0000 otherwise.
REQ-013 In GRANT, the block SHALL keep a hold counter hold_cnt that is 0 in the first grant cycle and increments by 1 each cycle the grant is held.
REQ-014 A release condition SHALL occur in any GRANT cycle where req[gnt_id]==0 or hold_cnt==MAX_HOLD-1.
REQ-015 On release, ptr SHALL become gnt_id+1 mod 4, so the just-served requester gets lowest priority.
REQ-016 On release with any req bit set, the block SHALL arbitrate in that same cycle using the updated ptr and grant the new winner on the next edge, with no idle bubble and hold_cnt reset to 0.
REQ-017 Under REQ-016, a requester released by timeout that is still the sole requester SHALL be re-granted immediately with a fresh hold_cnt.
REQ-018 On release with req == 0, the block SHALL enter IDLE on the next edge with gnt=0 and gnt_valid=0.
REQ-019 While in GRANT without release, gnt_id SHALL be stable; changes on other req bits SHALL have no effect.
REQ-020 At most one gnt bit SHALL be 1 in any cycle.
REQ-021 Every continuously asserted request SHALL be granted within 3*MAX_HOLD+1 cycles (starvation freedom).
REQ-022 hold_cnt SHALL be $clog2(MAX_HOLD) bits wide and SHALL never wrap, because release occurs at MAX_HOLD-1.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL set state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, ptr=2'b00 and hold_cnt=0, overriding all other conditions.
REQ-024 Reset asserted mid-grant SHALL drop the grant at that edge; after rst deasserts, arbitration SHALL restart from ptr=0.
REQ-025 With rst=0 and req=0 after reset, all outputs SHALL remain at their reset values.

Verification
REQ-026 The bench SHALL cover single request: after reset, req=0100 held 3 cycles then 0000 -> gnt=0100 and gnt_id=2 from the cycle after req rises until one cycle after it drops, then IDLE.
REQ-027 The bench SHALL cover round-robin: req=1111 with each winner dropping its bit after 1 cycle -> grant order 0,1,2,3, back-to-back with no zero-gnt cycle between.
REQ-028 The bench SHALL cover timeout with MAX_HOLD=8: req=0011 held constantly -> gnt=0001 for 8 cycles, then 0010 for 8, then 0001 for 8, repeating.
REQ-029 The bench SHALL cover sole-requester timeout with MAX_HOLD=8: req=1000 constant -> gnt=1000 continuously with no gap, and hold_cnt returning to 0 every 8 cycles.
REQ-030 The bench SHALL cover reset mid-grant: gnt=0100 active, rst=1 for 1 cycle with req=1100 -> gnt=0000 at that edge, then gnt=0100 (ptr=0 search finds bit 2 first) the cycle after rst falls.
REQ-031 The bench SHALL cover random req for 10k cycles -> gnt is always one-hot or zero, gnt matches decode(gnt_id) whenever gnt_valid=1, and no request waits more than 3*MAX_HOLD+1 cycles.
